i2c_cmd_bridge: RTL and testbench

I2C_CMD_BRIDGE -- requirements
Module: i2c_cmd_bridge

---
 rtl/i2c_cmd_bridge_pkg.sv | 37 +++
 rtl/i2c_cmd_buf.sv | 25 ++
 rtl/i2c_cmd_bridge.sv | 155 +++++++++++++++
 tb/tb_i2c_cmd_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cmd_bridge_pkg.sv
// Shared definitions for the host-command to I2C-master bridge: FSM states,
// status bit positions and buffer sizing helpers.
package i2c_cmd_bridge_pkg;

    typedef enum logic [3:0] {
        ST_HDR,
        ST_ADDR_LO,
        ST_RLEN_HI,
        ST_RLEN_LO,
        ST_WLEN,
        ST_PAYLOAD,
        ST_LOAD,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_DRAIN,
        ST_STATUS
    } state_t;

    localparam int unsigned STAT_AL          = 0;
    localparam int unsigned STAT_NAK         = 1;
    localparam int unsigned STAT_LEN_ERR     = 2;
    localparam int unsigned MAX_WLEN_DEFAULT = 16;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic logic [7:0] status_byte(input logic al, input logic nak, input logic len_err);
        logic [7:0] s;
        s = '0;
        s[STAT_AL]      = al;
        s[STAT_NAK]     = nak;
        s[STAT_LEN_ERR] = len_err;
        return s;
    endfunction

endpackage

// File: rtl/i2c_cmd_buf.sv
// Payload staging buffer: simple dual-port register file, synchronous write,
// combinational read. Contents are not reset.
module i2c_cmd_buf
    import i2c_cmd_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_WLEN_DEFAULT,
    parameter int unsigned IW    = idx_width(DEPTH)
) (
    input  logic          clk_in,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [7:0]    wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [2**IW];

    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/i2c_cmd_bridge.sv
// Parses host command bytes, stages the write payload, feeds the I2C master
// TX FIFO, forwards RX bytes to the host and terminates with a status byte.
module i2c_cmd_bridge
    import i2c_cmd_bridge_pkg::*;
#(
    parameter int unsigned MAX_WLEN = MAX_WLEN_DEFAULT
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic [7:0]  h2f_data_in,
    input  logic        h2f_valid_in,
    output logic        h2f_ready_out,
    output logic [7:0]  f2h_data_out,
    output logic        f2h_valid_out,
    input  logic        f2h_ready_in,
    output logic [7:0]  txf_din_out,
    output logic        txf_wr_out,
    input  logic        txf_full_in,
    input  logic [7:0]  rxf_dout_in,
    output logic        rxf_rd_out,
    input  logic        rxf_empty_in,
    output logic [9:0]  slave_addr_out,
    output logic        tenbit_out,
    output logic [15:0] bytes2read_out,
    input  logic        idle_in,
    input  logic        al_in,
    input  logic        nak_in
);

    localparam int unsigned IW = idx_width(MAX_WLEN);

    state_t      state;
    logic        alive;
    logic [7:0]  wlen;
    logic [7:0]  cnt;
    logic [1:0]  done_stat;
    logic        rd_pend;
    logic [7:0]  f2h_data;
    logic        f2h_valid;
    logic [9:0]  addr;
    logic        tenbit;
    logic [15:0] rlen;
    logic [7:0]  buf_rd;
    logic        h2f_acc;
    logic        f2h_acc;
    logic        rd_window;
    logic        last_byte;
    logic        buf_wr;

    // alive keeps ready low while reset is asserted even though state is HDR
    assign h2f_ready_out  = alive && (state inside {ST_HDR, ST_ADDR_LO, ST_RLEN_HI,
                                                    ST_RLEN_LO, ST_WLEN, ST_PAYLOAD});
    assign h2f_acc        = h2f_valid_in && h2f_ready_out;
    assign f2h_acc        = f2h_valid && f2h_ready_in;
    assign rd_window      = state inside {ST_WAIT_START, ST_WAIT_DONE, ST_DRAIN};
    assign rxf_rd_out     = rd_window && !rxf_empty_in && !rd_pend && !f2h_valid;
    assign txf_wr_out     = (state == ST_LOAD) && !txf_full_in;
    assign txf_din_out    = (state == ST_LOAD) ? buf_rd : '0;
    assign last_byte      = (cnt == wlen - 8'd1);
    assign buf_wr         = (state == ST_PAYLOAD) && h2f_acc;
    assign f2h_data_out   = f2h_data;
    assign f2h_valid_out  = f2h_valid;
    assign slave_addr_out = addr;
    assign tenbit_out     = tenbit;
    assign bytes2read_out = rlen;

    i2c_cmd_buf #(.DEPTH(MAX_WLEN)) u_buf (
        .clk_in  (clk_in),
        .wr_en   (buf_wr),
        .wr_idx  (cnt[IW-1:0]),
        .wr_data (h2f_data_in),
        .rd_idx  (cnt[IW-1:0]),
        .rd_data (buf_rd)
    );

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state     <= ST_HDR;
            alive     <= 1'b0;
            wlen      <= '0;
            cnt       <= '0;
            done_stat <= '0;
            rd_pend   <= 1'b0;
            f2h_data  <= '0;
            f2h_valid <= 1'b0;
            addr      <= '0;
            tenbit    <= 1'b0;
            rlen      <= '0;
        end else begin
            alive   <= 1'b1;
            rd_pend <= rxf_rd_out;
            if (f2h_acc) f2h_valid <= 1'b0;
            // RX data arrives the cycle after the pop; f2h is free by construction
            if (rd_pend) begin
                f2h_data  <= rxf_dout_in;
                f2h_valid <= 1'b1;
            end
            case (state)
                ST_HDR: if (h2f_acc) begin
                    tenbit    <= h2f_data_in[7];
                    addr[9:8] <= h2f_data_in[1:0];
                    state     <= ST_ADDR_LO;
                end
                ST_ADDR_LO: if (h2f_acc) begin
                    addr[7:0] <= h2f_data_in;
                    state     <= ST_RLEN_HI;
                end
                ST_RLEN_HI: if (h2f_acc) begin
                    rlen[15:8] <= h2f_data_in;
                    state      <= ST_RLEN_LO;
                end
                ST_RLEN_LO: if (h2f_acc) begin
                    rlen[7:0] <= h2f_data_in;
                    state     <= ST_WLEN;
                end
                ST_WLEN: if (h2f_acc) begin
                    wlen <= h2f_data_in;
                    cnt  <= '0;
                    if (h2f_data_in == 8'd0 || 32'(h2f_data_in) > MAX_WLEN) begin
                        f2h_data  <= status_byte(1'b0, 1'b0, 1'b1);
                        f2h_valid <= 1'b1;
                        state     <= ST_STATUS;
                    end else begin
                        state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: if (h2f_acc) begin
                    if (last_byte) begin
                        cnt   <= '0;
                        state <= ST_LOAD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_LOAD: if (!txf_full_in) begin
                    cnt <= cnt + 8'd1;
                    if (last_byte) state <= ST_WAIT_START;
                end
                ST_WAIT_START: if (!idle_in) state <= ST_WAIT_DONE;
                ST_WAIT_DONE: if (idle_in) begin
                    done_stat <= {nak_in, al_in};
                    state     <= ST_DRAIN;
                end
                ST_DRAIN: if (rxf_empty_in && !rd_pend && !f2h_valid) begin
                    f2h_data  <= status_byte(done_stat[0], done_stat[1], 1'b0);
                    f2h_valid <= 1'b1;
                    state     <= ST_STATUS;
                end
                ST_STATUS: if (f2h_acc) state <= ST_HDR;
                default: state <= ST_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_bridge.sv
// Randomised self-checking bench for i2c_cmd_bridge with a command-level
// reference model (expected TX payload and host response byte streams).
module tb_i2c_cmd_bridge;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic [7:0]  h2f_data_in;
    logic        h2f_valid_in;
    logic        h2f_ready_out;
    logic [7:0]  f2h_data_out;
    logic        f2h_valid_out;
    logic        f2h_ready_in;
    logic [7:0]  txf_din_out;
    logic        txf_wr_out;
    logic        txf_full_in;
    logic [7:0]  rxf_dout_in = 8'h00;
    logic        rxf_rd_out;
    logic        rxf_empty_in;
    logic [9:0]  slave_addr_out;
    logic        tenbit_out;
    logic [15:0] bytes2read_out;
    logic        idle_in;
    logic        al_in;
    logic        nak_in;

    i2c_cmd_bridge #(.MAX_WLEN(16)) dut (
        .clk_in         (clk_in),
        .reset_n_in     (reset_n_in),
        .h2f_data_in    (h2f_data_in),
        .h2f_valid_in   (h2f_valid_in),
        .h2f_ready_out  (h2f_ready_out),
        .f2h_data_out   (f2h_data_out),
        .f2h_valid_out  (f2h_valid_out),
        .f2h_ready_in   (f2h_ready_in),
        .txf_din_out    (txf_din_out),
        .txf_wr_out     (txf_wr_out),
        .txf_full_in    (txf_full_in),
        .rxf_dout_in    (rxf_dout_in),
        .rxf_rd_out     (rxf_rd_out),
        .rxf_empty_in   (rxf_empty_in),
        .slave_addr_out (slave_addr_out),
        .tenbit_out     (tenbit_out),
        .bytes2read_out (bytes2read_out),
        .idle_in        (idle_in),
        .al_in          (al_in),
        .nak_in         (nak_in)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed streams, captured mid-cycle ahead of the edge that commits them
    int         cyc = 0;
    logic [7:0] tx_got[$];
    int         tx_cyc[$];
    logic [7:0] f2h_got[$];
    logic       pop_req = 1'b0;

    // RX FIFO model: filled by the stimulus thread, popped by the DUT
    logic [7:0] rx_mem [256];
    int         rx_wp = 0;
    int         rx_rp = 0;
    assign rxf_empty_in = (rx_wp == rx_rp);

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (pop_req) begin
            rxf_dout_in <= rx_mem[rx_rp % 256];
            rx_rp       <= rx_rp + 1;
        end
    end

    always @(negedge clk_in) begin
        pop_req = reset_n_in && rxf_rd_out;
        if (reset_n_in) begin
            if (txf_wr_out) begin
                tx_got.push_back(txf_din_out);
                tx_cyc.push_back(cyc);
            end
            if (f2h_valid_out && f2h_ready_in) f2h_got.push_back(f2h_data_out);
        end
    end

    logic [7:0] pay [256];
    logic [7:0] rxb [256];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc = 0;
        h2f_data_in  = b;
        h2f_valid_in = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (h2f_ready_out) begin
                acc = 1;
                break;
            end
        end
        tick();
        h2f_valid_in = 1'b0;
        check_eq("h2f_accept", 32'(acc), 32'd1);
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_mem[rx_wp % 256] = b;
        rx_wp = rx_wp + 1;
    endtask

    // mode: 0 random TX-full, 1 TX never full, 2 TX full for 5 cycles at LOAD start,
    //       3 host stalls the first response byte for 10 cycles
    task automatic run_cmd(input bit tb, input int addr, input int rlen, input int wlen,
                           input int nrx, input bit al, input bit nak,
                           input int idle_lo, input int mode);
        logic [7:0]  exp_f2h[$];
        logic [7:0]  exp_tx[$];
        logic [9:0]  a;
        logic [15:0] r;
        bit          legal;
        int          pushed;
        a = addr[9:0];
        r = rlen[15:0];
        legal = (wlen >= 1) && (wlen <= 16);
        tx_got.delete();
        tx_cyc.delete();
        f2h_got.delete();
        f2h_ready_in = 1'b1;

        send_byte({tb, 5'b0, a[9:8]});
        send_byte(a[7:0]);
        send_byte(r[15:8]);
        send_byte(r[7:0]);
        send_byte(wlen[7:0]);

        if (legal) begin
            for (int i = 0; i < wlen; i++) begin
                exp_tx.push_back(pay[i]);
                txf_full_in = (mode == 2 && i == wlen - 1) ? 1'b1 : 1'b0;
                send_byte(pay[i]);
            end
            for (int c = 0; c < 400 && tx_got.size() < wlen; c++) begin
                if (mode == 2)      txf_full_in = (c < 5);
                else if (mode == 0) txf_full_in = ($urandom_range(0, 2) == 0);
                else                txf_full_in = 1'b0;
                tick();
            end
            txf_full_in = 1'b0;
            check_eq("tx_count", tx_got.size(), wlen);
            for (int i = 0; i < wlen && i < tx_got.size(); i++)
                check_eq("tx_byte", tx_got[i], exp_tx[i]);
            if (mode == 1)
                for (int i = 1; i < tx_got.size(); i++)
                    check_eq("tx_contiguous", tx_cyc[i] - tx_cyc[i-1], 1);

            for (int i = 0; i < nrx; i++) exp_f2h.push_back(rxb[i]);
            exp_f2h.push_back({6'b0, nak, al});

            repeat (3) tick();
            idle_in = 1'b0;
            pushed = 0;
            if (mode == 3 && nrx > 0) begin
                f2h_ready_in = 1'b0;
                for (int i = 0; i < nrx; i++) push_rx(rxb[i]);
                pushed = nrx;
                for (int c = 0; c < 30 && !f2h_valid_out; c++) @(negedge clk_in);
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk_in);
                    check_eq("f2h_hold_valid", f2h_valid_out, 1);
                    check_eq("f2h_hold_data", f2h_data_out, rxb[0]);
                end
                tick();
            end
            for (int c = 0; c < idle_lo; c++) begin
                if (pushed < nrx && $urandom_range(0, 1) == 1) begin
                    push_rx(rxb[pushed]);
                    pushed++;
                end
                f2h_ready_in = ($urandom_range(0, 3) != 0);
                tick();
            end
            while (pushed < nrx) begin
                push_rx(rxb[pushed]);
                pushed++;
            end
            al_in   = al;
            nak_in  = nak;
            idle_in = 1'b1;
            tick();
            al_in  = 1'b0;
            nak_in = 1'b0;
        end else begin
            exp_f2h.push_back(8'h04);
        end

        for (int c = 0; c < 600 && f2h_got.size() < exp_f2h.size(); c++) begin
            f2h_ready_in = ($urandom_range(0, 3) != 0);
            tick();
        end
        f2h_ready_in = 1'b1;
        repeat (5) tick();

        check_eq("f2h_count", f2h_got.size(), exp_f2h.size());
        for (int i = 0; i < exp_f2h.size() && i < f2h_got.size(); i++)
            check_eq("f2h_byte", f2h_got[i], exp_f2h[i]);
        check_eq("tx_total", tx_got.size(), legal ? wlen : 0);
        @(negedge clk_in);
        check_eq("slave_addr", slave_addr_out, a);
        check_eq("tenbit", tenbit_out, tb);
        check_eq("bytes2read", bytes2read_out, r);
        check_eq("ready_in_hdr", h2f_ready_out, 1);
        tick();
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_h2f_ready", h2f_ready_out, 0);
        check_eq("rst_f2h_valid", f2h_valid_out, 0);
        check_eq("rst_f2h_data", f2h_data_out, 0);
        check_eq("rst_txf_wr", txf_wr_out, 0);
        check_eq("rst_txf_din", txf_din_out, 0);
        check_eq("rst_rxf_rd", rxf_rd_out, 0);
        check_eq("rst_slave_addr", slave_addr_out, 0);
        check_eq("rst_tenbit", tenbit_out, 0);
        check_eq("rst_bytes2read", bytes2read_out, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wl, rl, nr, md;
        bit a_l, n_k;
        reset_n_in   = 1'b0;
        h2f_data_in  = '0;
        h2f_valid_in = 1'b0;
        f2h_ready_in = 1'b1;
        txf_full_in  = 1'b0;
        idle_in      = 1'b1;
        al_in        = 1'b0;
        nak_in       = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) tick();
        reset_n_in = 1'b1;
        tick();

        // write-only
        pay[0] = 8'hAA; pay[1] = 8'h55;
        run_cmd(0, 10'h050, 0, 2, 0, 0, 0, 20, 1);
        // write-then-read
        pay[0] = 8'h3C;
        rxb[0] = 8'h11; rxb[1] = 8'h22; rxb[2] = 8'h33;
        run_cmd(0, 10'h021, 3, 1, 3, 0, 0, 8, 1);
        // ten-bit address
        pay[0] = 8'h9E;
        run_cmd(1, 10'h345, 0, 1, 0, 0, 0, 4, 0);
        // length errors, then a normal command
        run_cmd(0, 10'h011, 2, 0, 0, 0, 0, 4, 0);
        run_cmd(1, 10'h2F0, 1, 17, 0, 0, 0, 4, 0);
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        run_cmd(0, 10'h012, 0, 3, 0, 0, 0, 5, 0);
        // NAK with no read data
        pay[0] = 8'h77;
        run_cmd(0, 10'h048, 4, 1, 0, 0, 1, 6, 0);
        // TX FIFO full for 5 cycles during LOAD
        for (int i = 0; i < 4; i++) pay[i] = 8'(8'hC0 + i);
        run_cmd(0, 10'h033, 0, 4, 0, 0, 0, 4, 2);
        // host stalls response for 10 cycles
        pay[0] = 8'h5A;
        rxb[0] = 8'hA1; rxb[1] = 8'hB2;
        run_cmd(0, 10'h066, 2, 1, 2, 0, 0, 4, 3);

        // reset mid-command: no status, next command unaffected
        f2h_got.delete();
        send_byte(8'h81);
        send_byte(8'h22);
        send_byte(8'h12);
        reset_n_in = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) tick();
        reset_n_in = 1'b1;
        repeat (10) tick();
        check_eq("reset_no_status", f2h_got.size(), 0);
        pay[0] = 8'hE1;
        rxb[0] = 8'h44;
        run_cmd(0, 10'h07A, 1, 1, 1, 0, 0, 5, 0);

        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 7) == 0) wl = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(17, 255);
            else                           wl = $urandom_range(1, 16);
            rl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : $urandom_range(0, 5);
            nr  = (rl > 6) ? 6 : rl;
            a_l = 0;
            n_k = 0;
            if (nr > 0 && $urandom_range(0, 2) == 0) nr = $urandom_range(0, nr - 1);
            if (nr < rl) begin
                if ($urandom_range(0, 1) == 1) a_l = 1;
                else                           n_k = 1;
            end
            for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
            for (int i = 0; i < 6; i++)  rxb[i] = 8'($urandom);
            md = $urandom_range(0, 1);
            run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), rl, wl, nr,
                    a_l, n_k, $urandom_range(2, 12), md);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
